// File: rtl/xge_rx_pkt_drain.sv
// Drains frames from the xge_mac pkt_rx interface, measures length, checks framing
// and publishes a one-cycle per-packet status record plus saturating counters.
module xge_rx_pkt_drain #(
  parameter int unsigned MAX_BYTES = 9600,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk_156m25,
  input  logic             reset_156m25_n,
  input  logic             enable,
  input  logic             stat_clr,
  input  logic             pkt_rx_avail,
  output logic             pkt_rx_ren,
  input  logic [63:0]      pkt_rx_data,
  input  logic             pkt_rx_val,
  input  logic             pkt_rx_sop,
  input  logic             pkt_rx_eop,
  input  logic [2:0]       pkt_rx_mod,
  input  logic             pkt_rx_err,
  output logic             busy,
  output logic             stat_done,
  output logic [15:0]      stat_len,
  output logic [3:0]       stat_flags,
  output logic [63:0]      stat_first_word,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned LEN_W  = 16;
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [3:0]        flags_q, flags_d;
  logic              seen_q, seen_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [63:0]       fw_q, fw_d;
  logic              publish;

  logic [3:0]        byte_add;
  logic [LEN_W:0]    len_sum;
  logic [LEN_W-1:0]  len_sat;
  logic [IDLE_W-1:0] idle_inc;

  // Per-word byte count and saturating length
  always_comb begin
    byte_add = (pkt_rx_eop && (pkt_rx_mod != 3'd0)) ? {1'b0, pkt_rx_mod} : 4'd8;
    len_sum  = {1'b0, len_q} + 17'(byte_add);
    len_sat  = len_sum[LEN_W] ? 16'hFFFF : len_sum[LEN_W-1:0];
    idle_inc = idle_q + IDLE_W'(1);
  end

  // Next-state and working-register update
  always_comb begin
    state_d    = state;
    len_d      = len_q;
    flags_d    = flags_q;
    seen_d     = seen_q;
    idle_d     = idle_q;
    fw_d       = fw_q;
    pkt_rx_ren = 1'b0;
    publish    = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable && pkt_rx_avail) begin
          state_d = S_READ;
          len_d   = '0;
          flags_d = '0;
          seen_d  = 1'b0;
          idle_d  = '0;
        end
      end
      S_READ: begin
        pkt_rx_ren = 1'b1;
        if (pkt_rx_val) begin
          idle_d = '0;
          len_d  = len_sat;
          seen_d = 1'b1;
          if (!seen_q) begin
            fw_d = pkt_rx_data;
            if (!pkt_rx_sop) flags_d[1] = 1'b1;
          end else if (pkt_rx_sop) begin
            flags_d[1] = 1'b1;
          end
          if (pkt_rx_err) flags_d[0] = 1'b1;
          if (32'(len_sat) > MAX_BYTES) flags_d[2] = 1'b1;
          if (pkt_rx_eop) begin
            pkt_rx_ren = 1'b0;
            state_d    = S_DONE;
            publish    = 1'b1;
          end
        end else begin
          idle_d = idle_inc;
          // TIMEOUT consecutive idle READ cycles abort the packet in this cycle
          if (32'(idle_inc) == TIMEOUT) begin
            flags_d[3] = 1'b1;
            pkt_rx_ren = 1'b0;
            state_d    = S_DONE;
            publish    = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, working registers, status record and counters
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      state           <= S_IDLE;
      len_q           <= '0;
      flags_q         <= '0;
      seen_q          <= 1'b0;
      idle_q          <= '0;
      fw_q            <= '0;
      busy            <= 1'b0;
      stat_done       <= 1'b0;
      stat_len        <= '0;
      stat_flags      <= '0;
      stat_first_word <= '0;
      pkt_cnt         <= '0;
      err_cnt         <= '0;
    end else begin
      state     <= state_d;
      len_q     <= len_d;
      flags_q   <= flags_d;
      seen_q    <= seen_d;
      idle_q    <= idle_d;
      fw_q      <= fw_d;
      busy      <= (state_d != S_IDLE);
      stat_done <= publish;
      if (publish) begin
        stat_len        <= len_d;
        stat_flags      <= flags_d;
        stat_first_word <= fw_d;
      end
      if (stat_clr) begin
        pkt_cnt <= '0;
        err_cnt <= '0;
      end else if (publish) begin
        if (pkt_cnt != '1) pkt_cnt <= pkt_cnt + CNT_W'(1);
        if ((flags_d != 4'd0) && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_xge_rx_pkt_drain.sv
// Randomized scoreboard bench for xge_rx_pkt_drain: a MAC-side driver predicts each
// packet's status record from frame-level rules; a monitor compares on stat_done.
module tb_xge_rx_pkt_drain;

  localparam int unsigned MAXB  = 64;
  localparam int unsigned TMO   = 16;
  localparam int unsigned CW    = 4;
  localparam int          CMAX  = 15;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic          stat_clr;
  logic          pkt_rx_avail;
  logic          pkt_rx_ren;
  logic [63:0]   pkt_rx_data;
  logic          pkt_rx_val;
  logic          pkt_rx_sop;
  logic          pkt_rx_eop;
  logic [2:0]    pkt_rx_mod;
  logic          pkt_rx_err;
  logic          busy;
  logic          stat_done;
  logic [15:0]   stat_len;
  logic [3:0]    stat_flags;
  logic [63:0]   stat_first_word;
  logic [CW-1:0] pkt_cnt;
  logic [CW-1:0] err_cnt;

  xge_rx_pkt_drain #(.MAX_BYTES(MAXB), .TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk_156m25     (clk),
    .reset_156m25_n (rst_n),
    .enable         (enable),
    .stat_clr       (stat_clr),
    .pkt_rx_avail   (pkt_rx_avail),
    .pkt_rx_ren     (pkt_rx_ren),
    .pkt_rx_data    (pkt_rx_data),
    .pkt_rx_val     (pkt_rx_val),
    .pkt_rx_sop     (pkt_rx_sop),
    .pkt_rx_eop     (pkt_rx_eop),
    .pkt_rx_mod     (pkt_rx_mod),
    .pkt_rx_err     (pkt_rx_err),
    .busy           (busy),
    .stat_done      (stat_done),
    .stat_len       (stat_len),
    .stat_flags     (stat_flags),
    .stat_first_word(stat_first_word),
    .pkt_cnt        (pkt_cnt),
    .err_cnt        (err_cnt)
  );

  typedef struct {
    logic [15:0] len;
    logic [3:0]  flags;
    logic [63:0] fw;
    int          pc;
    int          ec;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_pc     = 0;
  int   m_ec     = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every published status record against the scoreboard
  always @(negedge clk) begin
    if (rst_n && stat_done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_stat_done: got stat_done=1 with no packet expected (t=%0t)", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("stat_len", 64'(stat_len), 64'(e.len));
        check("stat_flags", 64'(stat_flags), 64'(e.flags));
        check("stat_first_word", stat_first_word, e.fw);
        check("pkt_cnt", 64'(pkt_cnt), 64'(e.pc));
        check("err_cnt", 64'(err_cnt), 64'(e.ec));
        check("busy_in_done", 64'(busy), 64'd1);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    pkt_rx_val  = 1'b0;
    pkt_rx_sop  = 1'b0;
    pkt_rx_eop  = 1'b0;
    pkt_rx_err  = 1'b0;
    pkt_rx_mod  = 3'($urandom);
    pkt_rx_data = {$urandom, $urandom};
  endtask

  task automatic drive_garbage();
    pkt_rx_val  = 1'($urandom);
    pkt_rx_sop  = 1'($urandom);
    pkt_rx_eop  = 1'($urandom);
    pkt_rx_err  = 1'($urandom);
    pkt_rx_mod  = 3'($urandom);
    pkt_rx_data = {$urandom, $urandom};
  endtask

  // Frame-level reference: length from word count and last-word byte count
  task automatic push_exp(input int nw, input logic [2:0] last_mod, input bit bad_first,
                          input int sop_idx, input int err_idx, input bit tmo,
                          input int clr_mode, input logic [63:0] w0);
    exp_t e;
    longint tot;
    tot = tmo ? 8 * nw : 8 * (nw - 1) + ((last_mod == 3'd0) ? 8 : int'(last_mod));
    e.len      = (tot > 65535) ? 16'hFFFF : 16'(tot);
    e.flags[0] = (err_idx >= 0) && (err_idx < nw);
    e.flags[1] = bad_first || ((sop_idx >= 1) && (sop_idx < nw));
    e.flags[2] = (tot > longint'(MAXB));
    e.flags[3] = tmo;
    e.fw       = w0;
    if (clr_mode == 1) begin
      m_pc = 0;
      m_ec = 0;
    end else begin
      if (m_pc < CMAX) m_pc++;
      if ((e.flags != 4'd0) && (m_ec < CMAX)) m_ec++;
    end
    e.pc = m_pc;
    e.ec = m_ec;
    exp_q.push_back(e);
    if (clr_mode == 2) begin
      m_pc = 0;
      m_ec = 0;
    end
  endtask

  // clr_mode: 0 none, 1 clear in the eop/abort cycle, 2 clear in the DONE cycle
  task automatic send_frame(input int nw, input logic [2:0] last_mod, input bit bad_first,
                            input int sop_idx, input int err_idx, input bit tmo,
                            input int clr_mode, input int max_gap, input int abort_after);
    logic [63:0] w0;
    logic [63:0] d;
    int          waited;
    bit          got;
    bit          last;
    w0 = '0;
    repeat ($urandom_range(1, 3)) begin
      next_cycle();
      drive_garbage();
      enable       = 1'b0;
      pkt_rx_avail = 1'($urandom);
      stat_clr     = ($urandom_range(0, 7) == 0);
      if (stat_clr) begin
        m_pc = 0;
        m_ec = 0;
      end
    end
    #1 check("busy_idle", 64'(busy), 64'd0);
    next_cycle();
    stat_clr     = 1'b0;
    enable       = 1'b1;
    pkt_rx_avail = 1'b1;
    drive_idle();
    #1 check("ren_idle", 64'(pkt_rx_ren), 64'd0);
    waited = 0;
    got    = 1'b0;
    while (!got && waited < 8) begin
      next_cycle();
      drive_idle();
      waited++;
      #1 if (pkt_rx_ren) got = 1'b1;
    end
    check("ren_latency", 64'(waited), 64'd1);
    pkt_rx_avail = 1'b0;
    for (int i = 0; i < nw; i++) begin
      repeat ($urandom_range(0, max_gap)) begin
        next_cycle();
        drive_idle();
        enable = 1'($urandom);
        #1 check("ren_gap", 64'(pkt_rx_ren), 64'd1);
      end
      next_cycle();
      d = {$urandom, $urandom};
      if (i == 0) w0 = d;
      last        = (i == nw - 1) && !tmo;
      pkt_rx_data = d;
      pkt_rx_val  = 1'b1;
      pkt_rx_sop  = (i == 0) ? !bad_first : (i == sop_idx);
      pkt_rx_eop  = last;
      pkt_rx_mod  = last ? last_mod : 3'($urandom);
      pkt_rx_err  = (i == err_idx);
      enable      = 1'($urandom);
      if (last) begin
        push_exp(nw, last_mod, bad_first, sop_idx, err_idx, tmo, clr_mode, w0);
        stat_clr = (clr_mode == 1);
      end
      #1 check("ren_word", 64'(pkt_rx_ren), 64'(!last));
      if (abort_after == i + 1) begin
        #1 rst_n = 1'b0;
        #1;
        check("rst_ren", 64'(pkt_rx_ren), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_stat_done", 64'(stat_done), 64'd0);
        check("rst_stat_len", 64'(stat_len), 64'd0);
        check("rst_stat_flags", 64'(stat_flags), 64'd0);
        check("rst_first_word", stat_first_word, 64'd0);
        check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
        drive_idle();
        enable   = 1'b0;
        stat_clr = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        m_pc  = 0;
        m_ec  = 0;
        return;
      end
    end
    if (tmo) begin
      push_exp(nw, last_mod, bad_first, sop_idx, err_idx, tmo, clr_mode, w0);
      for (int k = 1; k <= int'(TMO); k++) begin
        next_cycle();
        drive_idle();
        enable   = 1'($urandom);
        stat_clr = (clr_mode == 1) && (k == int'(TMO));
        #1 check("ren_timeout", 64'(pkt_rx_ren), 64'(k < int'(TMO)));
      end
    end
    next_cycle();
    drive_garbage();
    enable       = 1'b0;
    pkt_rx_avail = 1'($urandom);
    stat_clr     = (clr_mode == 2);
    #1 check("done_pulse", 64'(stat_done), 64'd1);
    next_cycle();
    stat_clr     = 1'b0;
    pkt_rx_avail = 1'b0;
    drive_idle();
    #1 check("busy_after_done", 64'(busy), 64'd0);
    if (clr_mode == 2) begin
      check("clr_pkt_cnt", 64'(pkt_cnt), 64'd0);
      check("clr_err_cnt", 64'(err_cnt), 64'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    enable       = 1'b0;
    stat_clr     = 1'b0;
    pkt_rx_avail = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    check("reset_ren", 64'(pkt_rx_ren), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_stat_done", 64'(stat_done), 64'd0);
    check("reset_stat_len", 64'(stat_len), 64'd0);
    check("reset_stat_flags", 64'(stat_flags), 64'd0);
    check("reset_first_word", stat_first_word, 64'd0);
    check("reset_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("reset_err_cnt", 64'(err_cnt), 64'd0);
    rst_n = 1'b1;

    send_frame(8, 3'd0, 0, -1, -1, 0, 0, 2, 0);   // 64 bytes, exactly at the limit
    send_frame(1, 3'd5, 0, -1, -1, 0, 0, 2, 0);   // single word, mod 5
    send_frame(1, 3'd0, 0, -1, -1, 0, 0, 2, 0);   // single word, mod 0
    send_frame(4, 3'd3, 0, -1, 3, 0, 0, 2, 0);    // MAC error on eop word
    send_frame(3, 3'd0, 1, -1, -1, 0, 0, 2, 0);   // missing sop
    send_frame(10, 3'd0, 0, -1, -1, 0, 0, 2, 0);  // oversize
    send_frame(3, 3'd0, 0, -1, -1, 1, 0, 2, 0);   // timeout after three words
    send_frame(5, 3'd2, 0, 2, -1, 0, 0, 2, 0);    // sop mid-frame
    send_frame(2, 3'd7, 0, -1, -1, 0, 2, 2, 0);   // clear in DONE cycle
    send_frame(2, 3'd1, 0, -1, 0, 0, 1, 2, 0);    // clear collides with increment
    send_frame(2, 3'd4, 0, -1, -1, 1, 1, 1, 0);   // clear collides with timeout

    for (int n = 0; n < 18; n++)
      send_frame($urandom_range(1, 4), 3'($urandom), 0, -1,
                 ($urandom_range(0, 2) == 0) ? 0 : -1, 0, 0, 1, 0);

    send_frame(4, 3'd0, 0, -1, -1, 0, 0, 2, 0);
    send_frame(6, 3'd0, 0, -1, -1, 0, 0, 2, 3);   // reset mid-frame
    send_frame(8, 3'd0, 0, -1, -1, 0, 0, 2, 0);   // first packet after reset

    send_frame(8200, 3'd0, 0, -1, -1, 0, 0, 0, 0); // length saturates at 0xFFFF

    for (int n = 0; n < 40; n++) begin
      int  nw;
      bit  tmo;
      nw  = $urandom_range(1, 12);
      tmo = ($urandom_range(0, 7) == 0);
      send_frame(nw, 3'($urandom), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 5) == 0) ? $urandom_range(1, 12) : -1,
                 ($urandom_range(0, 5) == 0) ? $urandom_range(0, 11) : -1,
                 tmo,
                 ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0,
                 3, 0);
    end

    repeat (4) next_cycle();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
